// File: rtl/sprite_rom_pkg.sv
// sprite_rom_pkg
// Shared definitions for the sprite streaming logic:
//   - sprite_id_e : the eight sprite/ROM selector codes
//   - state_e     : reader FSM states
//   - word_count  : number of 16-bit ROM words stored for each sprite
package sprite_rom_pkg;

  typedef enum logic [2:0] {
    BACKGROUND  = 3'd0,
    PLAYER      = 3'd1,
    ENEMY_A     = 3'd2,
    ENEMY_B     = 3'd3,
    ENEMY_C     = 3'd4,
    ENEMY_D     = 3'd5,
    WIN_SCREEN  = 3'd6,
    LOSE_SCREEN = 3'd7
  } sprite_id_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    LOAD  = 3'd2,
    HI    = 3'd3,
    LO    = 3'd4,
    FIN   = 3'd5
  } state_e;

  localparam int WORD_W = 16;

  // Words per sprite; every word carries two pixels.
  function automatic logic [WORD_W-1:0] word_count(input logic [2:0] id);
    logic [WORD_W-1:0] wc;
    case (id)
      BACKGROUND:  wc = 16'd64800;
      PLAYER:      wc = 16'd231;
      ENEMY_A:     wc = 16'd14196;
      ENEMY_B:     wc = 16'd14112;
      ENEMY_C:     wc = 16'd14028;
      ENEMY_D:     wc = 16'd14028;
      WIN_SCREEN:  wc = 16'd20880;
      default:     wc = 16'd24120;
    endcase
    return wc;
  endfunction

endpackage

// File: rtl/sprite_stream_reader.sv
// sprite_stream_reader
// Reads a sprite out of one of eight ROMs (reached through an external
// memory demux) and emits it as a valid/ready pixel stream, high byte of
// each 16-bit word first.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   START, SPRITE_ID   draw request and sprite selector (sampled in IDLE)
//   BUSY, DONE         transfer in progress / one-cycle completion pulse
//   SELECTOR           latched sprite id towards the demux
//   MEM_ADDR, MEM_DATA registered word address out, word back one clock later
//   PX_DATA, PX_VALID, PX_READY, PX_LAST   pixel stream
module sprite_stream_reader
  import sprite_rom_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int PX_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [2:0]        SPRITE_ID,
  output logic              BUSY,
  output logic              DONE,
  output logic [2:0]        SELECTOR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [15:0]       MEM_DATA,
  output logic [PX_W-1:0]   PX_DATA,
  output logic              PX_VALID,
  input  logic              PX_READY,
  output logic              PX_LAST
);

  state_e              state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   idx_q, idx_d;

  logic [WORD_W-1:0]   last_idx;
  logic [ADDR_W-1:0]   last_addr;
  logic [ADDR_W-1:0]   addr_inc;

  assign SELECTOR = sel_q;
  assign MEM_ADDR = addr_q;

  // The address runs one word ahead of the word register so the ROM's
  // one-clock latency is hidden; it stops at the last word instead of
  // running past the end of the sprite.
  always_comb begin
    last_idx  = word_count(sel_q) - 16'd1;
    last_addr = ADDR_W'(last_idx);
    addr_inc  = (addr_q >= last_addr) ? last_addr : addr_q + ADDR_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    word_d   = word_q;
    idx_d    = idx_q;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    PX_VALID = 1'b0;
    PX_LAST  = 1'b0;
    PX_DATA  = '0;

    case (state_q)
      IDLE: begin
        if (START) begin
          sel_d   = SPRITE_ID;
          addr_d  = '0;
          state_d = PRIME;
        end
      end
      // Address 0 is on the bus; wait for the ROM to return word 0.
      PRIME: begin
        BUSY    = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        BUSY    = 1'b1;
        word_d  = MEM_DATA;
        idx_d   = '0;
        addr_d  = addr_inc;
        state_d = HI;
      end
      HI: begin
        BUSY     = 1'b1;
        PX_VALID = 1'b1;
        PX_DATA  = PX_W'(word_q[15:8]);
        if (PX_READY) begin
          state_d = LO;
        end
      end
      // The next word has been on MEM_DATA since the address moved, so it
      // can be captured directly on the low-pixel handshake: no bubble.
      LO: begin
        BUSY     = 1'b1;
        PX_VALID = 1'b1;
        PX_DATA  = PX_W'(word_q[7:0]);
        PX_LAST  = (idx_q == last_idx);
        if (PX_READY) begin
          if (idx_q == last_idx) begin
            state_d = FIN;
          end else begin
            word_d  = MEM_DATA;
            idx_d   = idx_q + 16'd1;
            addr_d  = addr_inc;
            state_d = HI;
          end
        end
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_sprite_stream_reader.sv
// tb_sprite_stream_reader
// Drives sprite_stream_reader with a ROM model behind the demux and checks
// the pixel stream against a pixel-index reference model.
module tb_sprite_stream_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [2:0]  SPRITE_ID;
  logic        BUSY;
  logic        DONE;
  logic [2:0]  SELECTOR;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_DATA;
  logic [7:0]  PX_DATA;
  logic        PX_VALID;
  logic        PX_READY;
  logic        PX_LAST;

  int compared   = 0;
  int mismatched = 0;
  int cur_pix    = -1;
  bit chk_ok;

  int wc_table[8] = '{64800, 231, 14196, 14112, 14028, 14028, 20880, 24120};

  always #5 CLK = ~CLK;

  sprite_stream_reader #(.ADDR_W(16), .PX_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .SPRITE_ID (SPRITE_ID),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .SELECTOR  (SELECTOR),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DATA  (MEM_DATA),
    .PX_DATA   (PX_DATA),
    .PX_VALID  (PX_VALID),
    .PX_READY  (PX_READY),
    .PX_LAST   (PX_LAST)
  );

  // ROM contents: sprite 0 stores its own address, others are scrambled
  // by sprite id so a wrong selector shows up in the data.
  function automatic logic [15:0] rom_word(input logic [2:0] id, input logic [15:0] addr);
    logic [15:0] k;
    k = 16'(id) * 16'h1357;
    return addr ^ k;
  endfunction

  // Synchronous ROM behind the demux: one clock from address to data.
  always @(posedge CLK) begin
    MEM_DATA <= rom_word(SELECTOR, MEM_ADDR);
  end

  // Pixel p of a sprite is half of word p/2, high byte first.
  function automatic logic [7:0] exp_pixel(input int id, input int p);
    logic [15:0] w;
    w = rom_word(3'(id), 16'(p / 2));
    return (p % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    chk_ok = (obs === exp);
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s (pixel %0d): observed 0x%0h expected 0x%0h", tag, cur_pix, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Pulse reset and confirm every output returns to its cleared value.
  task automatic resetCheck();
    RST   = 1'b1;
    START = 1'b0;
    tick();
    RST = 1'b0;
    cur_pix = -1;
    checkOutput("rst_px_data",  32'(PX_DATA),  32'd0);
    checkOutput("rst_px_valid", 32'(PX_VALID), 32'd0);
    checkOutput("rst_px_last",  32'(PX_LAST),  32'd0);
    checkOutput("rst_busy",     32'(BUSY),     32'd0);
    checkOutput("rst_done",     32'(DONE),     32'd0);
    checkOutput("rst_selector", 32'(SELECTOR), 32'd0);
    checkOutput("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
    tick();
    checkOutput("rst_no_done",  32'(DONE),     32'd0);
    checkOutput("rst_idle",     32'(BUSY),     32'd0);
  endtask

  // mode 0: ready always high; mode 1: ready toggles 1-0 then random
  // stalls; mode 2: ready high with START/SPRITE_ID=3 pulsed mid-transfer
  // and during the completion cycle. abort_at >= 0 stops after that many
  // accepted pixels, leaving the DUT mid-transfer for the caller.
  task automatic applyStimulus(input int id, input int mode, input int abort_at);
    int npix, last_addr, p, cyc, max_addr;
    bit bad, prev_stall;
    logic [7:0]  prev_data;
    logic        prev_last;
    logic [15:0] prev_addr;
    npix = 2 * wc_table[id];
    last_addr = wc_table[id] - 1;
    p = 0; cyc = 0; max_addr = 0; bad = 0; prev_stall = 0;
    prev_data = '0; prev_last = 1'b0; prev_addr = '0;
    cur_pix = -1;

    SPRITE_ID = 3'(id);
    START     = 1'b1;
    PX_READY  = (mode != 1);
    tick();
    START = 1'b0;
    checkOutput("busy_after_start", 32'(BUSY),     32'd1);
    checkOutput("valid_in_prime",   32'(PX_VALID), 32'd0);
    checkOutput("selector_latched", 32'(SELECTOR), 32'(id));
    checkOutput("addr_starts_zero", 32'(MEM_ADDR), 32'd0);
    tick();
    checkOutput("valid_in_load",    32'(PX_VALID), 32'd0);
    tick();

    while (p < npix && !bad && cyc < npix * 4 + 100) begin
      if (abort_at >= 0 && p == abort_at) break;
      cur_pix = p;
      checkOutput("px_valid", 32'(PX_VALID), 32'd1);
      if (!chk_ok) bad = 1;
      checkOutput("px_data", 32'(PX_DATA), 32'(exp_pixel(id, p)));
      if (!chk_ok) bad = 1;
      checkOutput("px_last", 32'(PX_LAST), 32'(p == npix - 1));
      if (!chk_ok) bad = 1;
      checkOutput("busy_during", 32'(BUSY), 32'd1);
      if (!chk_ok) bad = 1;
      checkOutput("done_early", 32'(DONE), 32'd0);
      if (!chk_ok) bad = 1;
      checkOutput("selector_stable", 32'(SELECTOR), 32'(id));
      if (!chk_ok) bad = 1;
      checkOutput("addr_saturate", (int'(MEM_ADDR) <= last_addr) ? 32'd1 : 32'd0, 32'd1);
      if (!chk_ok) bad = 1;
      if (prev_stall) begin
        checkOutput("stall_hold_data", 32'(PX_DATA),  32'(prev_data));
        if (!chk_ok) bad = 1;
        checkOutput("stall_hold_last", 32'(PX_LAST),  32'(prev_last));
        if (!chk_ok) bad = 1;
        checkOutput("stall_hold_addr", 32'(MEM_ADDR), 32'(prev_addr));
        if (!chk_ok) bad = 1;
      end
      if (int'(MEM_ADDR) > max_addr) max_addr = int'(MEM_ADDR);

      case (mode)
        1: PX_READY = (p < 400) ? (cyc % 2 == 0) : ($urandom_range(7) != 0);
        default: PX_READY = 1'b1;
      endcase
      if (mode == 2) begin
        START     = ((p >= 50 && p < 60) || p == npix - 1);
        SPRITE_ID = START ? 3'd3 : 3'(id);
      end

      prev_stall = !PX_READY;
      prev_data  = PX_DATA;
      prev_last  = PX_LAST;
      prev_addr  = MEM_ADDR;
      if (PX_READY) p++;
      cyc++;
      tick();
    end

    if (abort_at >= 0 && p == abort_at && !bad) return;
    if (bad) begin
      resetCheck();
      return;
    end
    if (p != npix) begin
      checkOutput("stream_timeout", 32'(p), 32'(npix));
      resetCheck();
      return;
    end

    cur_pix = npix;
    checkOutput("done_pulse",     32'(DONE),     32'd1);
    checkOutput("busy_in_done",   32'(BUSY),     32'd0);
    checkOutput("valid_in_done",  32'(PX_VALID), 32'd0);
    checkOutput("last_in_done",   32'(PX_LAST),  32'd0);
    checkOutput("addr_max",       32'(max_addr), 32'(last_addr));
    if (mode == 0) checkOutput("throughput_cycles", 32'(cyc), 32'(npix));

    // In mode 2 START is still high through the completion cycle.
    tick();
    START = 1'b0;
    checkOutput("done_one_cycle", 32'(DONE), 32'd0);
    checkOutput("idle_after_done", 32'(BUSY), 32'd0);
    tick();
    checkOutput("no_extra_done", 32'(DONE), 32'd0);
    checkOutput("still_idle",    32'(BUSY), 32'd0);
    checkOutput("selector_hold_idle", 32'(SELECTOR), 32'(id));
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; SPRITE_ID = 3'd0; PX_READY = 1'b0;
    tick();
    tick();
    checkOutput("init_busy",     32'(BUSY),     32'd0);
    checkOutput("init_done",     32'(DONE),     32'd0);
    checkOutput("init_valid",    32'(PX_VALID), 32'd0);
    checkOutput("init_last",     32'(PX_LAST),  32'd0);
    checkOutput("init_data",     32'(PX_DATA),  32'd0);
    checkOutput("init_selector", 32'(SELECTOR), 32'd0);
    checkOutput("init_addr",     32'(MEM_ADDR), 32'd0);
    RST = 1'b0;
    tick();

    // Reset wins over a simultaneous START.
    SPRITE_ID = 3'd5; START = 1'b1; RST = 1'b1;
    tick();
    START = 1'b0; RST = 1'b0;
    checkOutput("rst_start_busy",  32'(BUSY),     32'd0);
    checkOutput("rst_start_valid", 32'(PX_VALID), 32'd0);
    checkOutput("rst_start_sel",   32'(SELECTOR), 32'd0);
    tick();
    checkOutput("rst_start_idle",  32'(BUSY),     32'd0);

    // Short sprite, full rate.
    applyStimulus(1, 0, -1);
    // Same sprite with START/ID=3 hammered while busy and at completion.
    applyStimulus(1, 2, -1);
    // Background sprite: words equal their address; first 600 pixels.
    applyStimulus(0, 0, 600);
    resetCheck();
    // Abort at pixel 100, then a fresh start must begin at address 0.
    applyStimulus(2, 0, 100);
    resetCheck();
    applyStimulus(2, 0, 60);
    resetCheck();
    // Full sprite 6 under back-pressure.
    applyStimulus(6, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sprite_stream_reader.md
SPRITE_STREAM_READER -- requirements
Module: sprite_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning width of MEM_ADDR.
REQ-002 SHALL have parameter PX_W, default 8, meaning pixel width; two pixels are packed per 16-bit ROM word.
REQ-003 CLK  in  1  sole clock; also drives the ROM clock routed through the memory demux.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 START  in  1  draw request; sampled only in IDLE.
REQ-006 SPRITE_ID  in  3  sprite/ROM selector code 0..7; latched on accepted START.
REQ-007 BUSY  out  1  high from the cycle after accepted START until DONE.
REQ-008 DONE  out  1  one-cycle pulse after the last pixel is accepted.
REQ-009 SELECTOR  out  3  to demux; latched SPRITE_ID.
REQ-010 MEM_ADDR  out  ADDR_W  word address to demux, registered.
REQ-011 MEM_DATA  in  16  word from demux; ROM latency is one clock from MEM_ADDR.
REQ-012 PX_DATA  out  PX_W  pixel stream data.
REQ-013 PX_VALID  out  1  PX_DATA valid.
REQ-014 PX_READY  in  1  sink accepts when PX_VALID && PX_READY.
REQ-015 PX_LAST  out  1  high with the final pixel of the sprite.

Function
REQ-016 SHALL use states IDLE, PRIME, LOAD, HI, LO, FIN.
REQ-017 IDLE: START=1 -> latch SPRITE_ID to SELECTOR, MEM_ADDR<=0, go PRIME; START outside IDLE SHALL be ignored.
REQ-018 PRIME: one cycle, no output -> LOAD.
REQ-019 LOAD: capture MEM_DATA into word register, word index<=0, MEM_ADDR<=1, go HI; PX_VALID first rises 2 cycles after START is sampled.
REQ-020 HI: PX_DATA=word[15:8], PX_VALID=1; on accept -> LO.
REQ-021 LO: PX_DATA=word[7:0], PX_VALID=1; on accept, if word index = WORD_COUNT-1 -> FIN, else capture MEM_DATA, increment word index, increment MEM_ADDR, go HI.
REQ-022 MEM_ADDR SHALL saturate at WORD_COUNT-1, never exceed it.
REQ-023 With PX_READY held high, throughput SHALL be one pixel per cycle, no bubbles after the first pixel.
REQ-024 While PX_VALID && !PX_READY, PX_DATA, PX_LAST, SELECTOR and MEM_ADDR SHALL hold stable.
REQ-025 PX_LAST SHALL be high only in LO when word index = WORD_COUNT-1.
REQ-026 FIN: DONE=1 for one cycle, BUSY=0, -> IDLE; START in FIN ignored.
REQ-027 WORD_COUNT per SPRITE_ID 0..7: 64800, 231, 14196, 14112, 14028, 14028, 20880, 24120; pixels per sprite = 2 x WORD_COUNT.
REQ-028 SELECTOR SHALL hold its last value in IDLE.

Reset
REQ-029 RST SHALL, at the next CLK edge, force IDLE; SELECTOR=0, MEM_ADDR=0, word register=0, word index=0, PX_DATA=0, PX_VALID=0, PX_LAST=0, BUSY=0, DONE=0.
REQ-030 RST mid-transfer SHALL abort without a DONE pulse; the next START behaves as after power-up.
REQ-031 RST SHALL take priority over START in the same cycle.

Structure
REQ-032 Package sprite_rom_pkg SHALL hold the eight sprite ID codes (BACKGROUND=0 ... LOSE_SCREEN=7) and the WORD_COUNT table/function.
REQ-033 No sub-module; the FSM, address counter and word register reside in one module.

Verification
REQ-034 ID=1, READY=1 constant -> VALID 2 cycles after START, 462 contiguous pixels, LAST on #462, DONE next cycle, MEM_ADDR max 230.
REQ-035 ID=0, ROM word = address -> pixel pairs {addr[15:8],addr[7:0]} for addr 0..64799, 129600 pixels total.
REQ-036 ID=6, READY toggled 1-0-1-0 -> data held while stalled, sequence intact, 41760 pixels.
REQ-037 START asserted during BUSY with ID=3 -> ignored, SELECTOR stays at original ID, no extra DONE.
REQ-038 RST at pixel 100 of ID=2 -> outputs zero next cycle, no DONE; fresh START ID=2 -> restarts from address 0.
REQ-039 START and RST together -> stays IDLE, BUSY=0.
